uart_rx_cfg: RTL

Parametrised UART receiver, successor to the fixed 8N1 receiver in the processor's serial loader path.
- Frame format set at elaboration: clocks-per-bit, data width, parity mode, stop-bit count.
- Reports parity error, framing error and line break alongside each received word.
- Sits between the board RX pin and the instruction/data loader; one word per o_rx_dv pulse.

---
 rtl/uart_rx_cfg.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver for the serial loader path: elaboration-time frame format,
// reports parity error, framing error and line break alongside each received word.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx_serial,
    output logic                 o_rx_dv,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic PARITY_EN  = (PARITY_MODE != 0);
    localparam logic ODD_PARITY = (PARITY_MODE == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP,
        S_WAIT_IDLE
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic                 r_sync1;
    logic                 r_rxS;
    logic [CNT_W-1:0]     r_bitCnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_parAcc;
    logic                 r_frameErr;
    logic                 r_allZero;

    logic                 r_rxDv;
    logic [DATA_BITS-1:0] r_rxByte;
    logic                 r_parityErrOut;
    logic                 r_frameErrOut;
    logic                 r_breakOut;

    logic w_cntClr;
    logic w_cntInc;
    logic w_idxClr;
    logic w_sampleData;
    logic w_samplePar;
    logic w_sampleStop;
    logic w_frameDone;
    logic w_halfDone;
    logic w_bitDone;

    assign w_halfDone = (r_bitCnt == HALF_CNT);
    assign w_bitDone  = (r_bitCnt == FULL_CNT);

    always_comb begin
        w_nextState  = r_state;
        w_cntClr     = 1'b0;
        w_cntInc     = 1'b0;
        w_idxClr     = 1'b0;
        w_sampleData = 1'b0;
        w_samplePar  = 1'b0;
        w_sampleStop = 1'b0;
        w_frameDone  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cntClr = 1'b1;
                w_idxClr = 1'b1;
                if (!r_rxS) begin
                    w_nextState = S_START;
                end
            end
            S_START: begin
                if (w_halfDone) begin
                    w_cntClr    = 1'b1;
                    w_nextState = r_rxS ? S_IDLE : S_DATA;
                end else begin
                    w_cntInc = 1'b1;
                end
            end
            S_DATA: begin
                if (w_bitDone) begin
                    w_cntClr     = 1'b1;
                    w_sampleData = 1'b1;
                    if (r_idx == LAST_DATA) begin
                        w_idxClr    = 1'b1;
                        w_nextState = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end else begin
                    w_cntInc = 1'b1;
                end
            end
            S_PARITY: begin
                if (w_bitDone) begin
                    w_cntClr    = 1'b1;
                    w_samplePar = 1'b1;
                    w_nextState = S_STOP;
                end else begin
                    w_cntInc = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bitDone) begin
                    w_cntClr     = 1'b1;
                    w_sampleStop = 1'b1;
                    if (r_idx == LAST_STOP) begin
                        w_idxClr    = 1'b1;
                        w_frameDone = 1'b1;
                        w_nextState = S_CLEANUP;
                    end
                end else begin
                    w_cntInc = 1'b1;
                end
            end
            S_CLEANUP: begin
                w_cntClr    = 1'b1;
                w_nextState = r_rxS ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                w_cntClr = 1'b1;
                if (r_rxS) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Output registers load on the final stop sample so they are valid exactly in CLEANUP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_sync1        <= 1'b1;
            r_rxS          <= 1'b1;
            r_bitCnt       <= '0;
            r_idx          <= '0;
            r_data         <= '0;
            r_parAcc       <= 1'b0;
            r_frameErr     <= 1'b0;
            r_allZero      <= 1'b1;
            r_rxDv         <= 1'b0;
            r_rxByte       <= '0;
            r_parityErrOut <= 1'b0;
            r_frameErrOut  <= 1'b0;
            r_breakOut     <= 1'b0;
        end else begin
            r_sync1 <= i_rx_serial;
            r_rxS   <= r_sync1;
            r_state <= w_nextState;

            if (w_cntClr) begin
                r_bitCnt <= '0;
            end else if (w_cntInc) begin
                r_bitCnt <= r_bitCnt + CNT_W'(1);
            end

            if (w_idxClr) begin
                r_idx <= '0;
            end else if (w_sampleData || w_sampleStop) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            if (r_state == S_IDLE) begin
                r_parAcc   <= 1'b0;
                r_frameErr <= 1'b0;
                r_allZero  <= 1'b1;
            end
            if (w_sampleData) begin
                r_data    <= {r_rxS, r_data[DATA_BITS-1:1]};
                r_parAcc  <= r_parAcc ^ r_rxS;
                r_allZero <= r_allZero & ~r_rxS;
            end
            if (w_samplePar) begin
                r_parAcc  <= r_parAcc ^ r_rxS;
                r_allZero <= r_allZero & ~r_rxS;
            end
            if (w_sampleStop) begin
                r_frameErr <= r_frameErr | ~r_rxS;
                r_allZero  <= r_allZero & ~r_rxS;
            end

            r_rxDv         <= w_frameDone;
            r_parityErrOut <= w_frameDone & PARITY_EN & (r_parAcc != ODD_PARITY);
            r_frameErrOut  <= w_frameDone & (r_frameErr | ~r_rxS);
            r_breakOut     <= w_frameDone & r_allZero & ~r_rxS;
            if (w_frameDone) begin
                r_rxByte <= r_data;
            end
        end
    end

    assign o_rx_dv      = r_rxDv;
    assign o_rx_byte    = r_rxByte;
    assign o_parity_err = r_parityErrOut;
    assign o_frame_err  = r_frameErrOut;
    assign o_break      = r_breakOut;
    assign o_busy       = (r_state != S_IDLE);

endmodule
